// File: rtl/elink_trig_wb_reader.sv
// Wishbone read master that sweeps a wrapping address range of the triplicated
// trigger memory scrubber and streams each voted word out over valid/ready.
module elink_trig_wb_reader #(
    parameter int ADDR_W   = 4,
    parameter int MAX_ADDR = 3,
    parameter int DATA_W   = 12,
    parameter int TIMEOUT  = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W:0]   num_words,
    output logic              busy,
    output logic              done,
    output logic              timeout_err,
    output logic [ADDR_W-1:0] o_wb_addr,
    output logic              o_wb_stb,
    input  logic [DATA_W-1:0] i_wb_data,
    input  logic              i_wb_ack,
    input  logic              i_wb_stall,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_valid,
    input  logic              out_ready
);
    localparam int TMR_W = $clog2(TIMEOUT);

    typedef enum logic [2:0] {IDLE, REQ, WAIT_ACK, HOLD, FIN} state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] cur_addr;
    logic [ADDR_W:0]   remaining;
    logic [TMR_W-1:0]  timer;
    logic              ack_armed;
    logic              start_ok, issue, qual_ack, tmo_hit, accepted;

    // An ack only counts once it has been seen low during this read, so a level
    // ack left high by the previous read cannot be mistaken for this one.
    always_comb begin
        start_ok = (state == IDLE) && start;
        issue    = (state == REQ) && !i_wb_stall;
        qual_ack = (state == WAIT_ACK) && i_wb_ack && ack_armed;
        tmo_hit  = (state == WAIT_ACK) && !qual_ack && (timer == TMR_W'(TIMEOUT - 1));
        accepted = (state == HOLD) && out_valid && out_ready;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (start_ok) state_nxt = (num_words == '0) ? FIN : REQ;
            REQ:      if (issue) state_nxt = WAIT_ACK;
            WAIT_ACK: begin
                if (qual_ack)     state_nxt = HOLD;
                else if (tmo_hit) state_nxt = FIN;
            end
            HOLD:     if (accepted) state_nxt = (remaining == '0) ? FIN : REQ;
            FIN:      state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy        <= 1'b0;
            done        <= 1'b0;
            timeout_err <= 1'b0;
            o_wb_addr   <= '0;
            o_wb_stb    <= 1'b0;
            out_data    <= '0;
            out_addr    <= '0;
            out_valid   <= 1'b0;
            cur_addr    <= '0;
            remaining   <= '0;
            timer       <= '0;
            ack_armed   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start_ok) begin
                cur_addr    <= start_addr;
                remaining   <= num_words;
                timeout_err <= 1'b0;
                busy        <= 1'b1;
            end
            if (state == REQ) o_wb_addr <= cur_addr;
            if (issue) begin
                o_wb_stb  <= 1'b1;
                ack_armed <= 1'b0;
                timer     <= '0;
            end
            if (state == WAIT_ACK) begin
                timer <= timer + 1'b1;
                if (!i_wb_ack) ack_armed <= 1'b1;
            end
            if (qual_ack) begin
                out_data  <= i_wb_data;
                out_addr  <= cur_addr;
                out_valid <= 1'b1;
                o_wb_stb  <= 1'b0;
                remaining <= remaining - 1'b1;
                cur_addr  <= (cur_addr == ADDR_W'(MAX_ADDR)) ? '0 : cur_addr + 1'b1;
            end
            if (tmo_hit) begin
                o_wb_stb    <= 1'b0;
                timeout_err <= 1'b1;
            end
            if (accepted) out_valid <= 1'b0;
            if (state == FIN) begin
                done <= 1'b1;
                busy <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_elink_trig_wb_reader.sv
// Randomized scoreboard bench: a scrubber model answers reads, expected words
// come from plain address arithmetic over the bench's memory image.
module tb_elink_trig_wb_reader;
    localparam int AW = 4, DW = 12, MAXA = 3, TMO = 64;
    localparam logic [DW-1:0] JUNK = 12'hBAD;

    logic          clk = 0, rst_n = 0;
    logic          start = 0;
    logic [AW-1:0] start_addr = 0;
    logic [AW:0]   num_words = 0;
    logic          busy, done, timeout_err, o_wb_stb, out_valid;
    logic [AW-1:0] o_wb_addr, out_addr;
    logic [DW-1:0] i_wb_data, out_data;
    logic          i_wb_ack, i_wb_stall, out_ready;

    elink_trig_wb_reader #(.ADDR_W(AW), .MAX_ADDR(MAXA), .DATA_W(DW), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .start_addr(start_addr),
        .num_words(num_words), .busy(busy), .done(done), .timeout_err(timeout_err),
        .o_wb_addr(o_wb_addr), .o_wb_stb(o_wb_stb), .i_wb_data(i_wb_data),
        .i_wb_ack(i_wb_ack), .i_wb_stall(i_wb_stall), .out_data(out_data),
        .out_addr(out_addr), .out_valid(out_valid), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    logic [DW-1:0]    mem [0:MAXA];
    logic [AW+DW-1:0] exp_q[$];
    int  total = 0, bad = 0;
    int  stb_cycles = 0, done_cnt = 0;
    int  d0, s0;
    bit  no_ack = 0, sticky_ack = 0, stall_block = 0, rand_stall = 0;
    bit  ready_block = 0, rand_ready = 0;

    function automatic void check(input bit ok, input string name, input longint act, input longint expv);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endfunction

    // Scrubber model: level ack, optional stale ack carried over from the previous read
    initial begin
        int c, ack_at, stale_len;
        bit served;
        c = 0; ack_at = 1; stale_len = 0; served = 0;
        i_wb_ack = 0; i_wb_stall = 0; i_wb_data = 0;
        forever begin
            @(posedge clk); #1;
            i_wb_stall = stall_block || (rand_stall && !o_wb_stb && $urandom_range(0, 2) == 0);
            if (!o_wb_stb) begin
                c = 0; served = 0;
                if (sticky_ack && i_wb_ack) i_wb_data = JUNK;
                else i_wb_ack = 0;
            end else begin
                if (c == 0) begin
                    stale_len = i_wb_ack ? int'($urandom_range(1, 3)) : 0;
                    ack_at    = stale_len + int'($urandom_range(1, 4));
                end
                if (no_ack) i_wb_ack = 0;
                else if (!served) begin
                    if (c < stale_len) begin i_wb_ack = 1; i_wb_data = JUNK; end
                    else if (c < ack_at) i_wb_ack = 0;
                    else begin
                        i_wb_ack  = 1;
                        i_wb_data = (o_wb_addr <= AW'(MAXA)) ? mem[o_wb_addr] : 12'hEEE;
                        served    = 1;
                    end
                end
                c++;
            end
        end
    end

    initial begin
        out_ready = 1;
        forever begin
            @(posedge clk); #1;
            out_ready = ready_block ? 1'b0 : (rand_ready ? 1'($urandom_range(0, 1)) : 1'b1);
        end
    end

    // Monitor: scoreboard pops plus protocol invariants
    initial begin
        bit have_prev, prev_stb, prev_stall;
        logic [AW+DW-1:0] prev_word, e;
        have_prev = 0; prev_stb = 0; prev_stall = 0; prev_word = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                have_prev = 0; prev_stb = 0; prev_stall = 0;
            end else begin
                if (o_wb_stb) stb_cycles++;
                if (done) done_cnt++;
                if (o_wb_stb && !prev_stb) check(!prev_stall, "stb_rise_in_stall", prev_stall, 0);
                if (out_valid) check(!o_wb_stb, "stb_while_valid", o_wb_stb, 0);
                if (have_prev)
                    check(out_valid && {out_addr, out_data} == prev_word, "valid_stable",
                          {out_valid, out_addr, out_data}, {1'b1, prev_word});
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) check(0, "unexpected_word", {out_addr, out_data}, 0);
                    else begin
                        e = exp_q.pop_front();
                        check({out_addr, out_data} == e, "word", {out_addr, out_data}, e);
                    end
                    have_prev = 0;
                end else if (out_valid) begin
                    have_prev = 1; prev_word = {out_addr, out_data};
                end else have_prev = 0;
                prev_stb = o_wb_stb; prev_stall = i_wb_stall;
            end
        end
    end

    task automatic start_sweep(input int sa, input int nw, input bit exp_to);
        int a;
        if (!exp_to)
            for (int i = 0; i < nw; i++) begin
                a = (sa + i) % (MAXA + 1);
                exp_q.push_back({AW'(a), mem[a]});
            end
        d0 = done_cnt; s0 = stb_cycles;
        @(posedge clk); #1;
        start = 1; start_addr = AW'(sa); num_words = (AW+1)'(nw);
        @(posedge clk); #1;
        start = 0;
        check(busy == 1 && timeout_err == 0, "start_accept", {busy, timeout_err}, 2);
    endtask

    task automatic wait_done(input bit exp_to, input string name);
        int cyc;
        cyc = 0;
        while (done_cnt == d0 && cyc < 3000) begin @(posedge clk); cyc++; end
        check(done_cnt == d0 + 1, {name, "_done"}, done_cnt - d0, 1);
        @(negedge clk);
        check(busy == 0 && timeout_err == exp_to, {name, "_end_flags"}, {busy, timeout_err}, {1'b0, exp_to});
        check(exp_q.size() == 0, {name, "_words_left"}, exp_q.size(), 0);
        if (exp_to) check(stb_cycles - s0 == TMO, {name, "_stb_cycles"}, stb_cycles - s0, TMO);
        exp_q.delete();
    endtask

    initial begin
        bit ok;
        int cyc;
        logic [AW+DW-1:0] w;
        for (int i = 0; i <= MAXA; i++) mem[i] = DW'(12'h0A0 + i);

        // reset state
        repeat (2) @(negedge clk);
        check({busy, done, timeout_err, o_wb_stb, out_valid, o_wb_addr, out_addr, out_data} == 0,
              "reset_state", {busy, done, timeout_err, o_wb_stb, out_valid, o_wb_addr, out_addr, out_data}, 0);
        rst_n = 1;

        // wrapping sweep from address 2
        start_sweep(2, 4, 0);
        wait_done(0, "wrap4");

        // stale level ack must not be captured
        sticky_ack = 1;
        start_sweep(0, 5, 0);
        wait_done(0, "stale_ack");
        sticky_ack = 0;

        // 20 cycles of stall at request
        stall_block = 1;
        start_sweep(3, 2, 0);
        ok = 1;
        repeat (20) begin @(negedge clk); ok &= !o_wb_stb && !timeout_err; end
        check(ok, "stall_hold", o_wb_stb, 0);
        stall_block = 0;
        wait_done(0, "stall");

        // downstream backpressure after the first word
        ready_block = 1;
        start_sweep(1, 3, 0);
        cyc = 0;
        do begin @(negedge clk); cyc++; end while (!out_valid && cyc < 200);
        check(out_valid, "bp_first_valid", out_valid, 1);
        w = {out_addr, out_data};
        ok = 1;
        repeat (10) begin @(negedge clk); ok &= out_valid && {out_addr, out_data} == w && !o_wb_stb; end
        check(ok, "bp_hold", {out_valid, out_addr, out_data}, {1'b1, w});
        ready_block = 0;
        wait_done(0, "backpressure");

        // empty sweep: done two cycles after start
        d0 = done_cnt;
        @(posedge clk); #1; start = 1; start_addr = 0; num_words = 0;
        @(posedge clk); #1; start = 0;
        @(negedge clk);
        check(done == 0 && busy == 1, "empty_c1", {done, busy}, 1);
        @(negedge clk);
        check(done == 1 && busy == 0, "empty_c2", {done, busy}, 2);

        // timeout, then the next start clears the error
        no_ack = 1;
        start_sweep(0, 3, 1);
        wait_done(1, "timeout");
        no_ack = 0;
        start_sweep(2, 2, 0);
        wait_done(0, "after_timeout");

        // reset while a read is outstanding
        no_ack = 1;
        start_sweep(1, 3, 1);
        cyc = 0;
        do begin @(negedge clk); cyc++; end while (!o_wb_stb && cyc < 50);
        repeat (3) @(negedge clk);
        #2 rst_n = 0;
        #1 check({busy, done, timeout_err, o_wb_stb, out_valid, o_wb_addr, out_addr, out_data} == 0,
                 "midreset_outputs", {busy, done, timeout_err, o_wb_stb, out_valid, o_wb_addr}, 0);
        no_ack = 0;
        @(negedge clk); rst_n = 1;
        d0 = done_cnt;
        repeat (6) @(negedge clk);
        check(busy == 0 && o_wb_stb == 0 && done_cnt == d0, "midreset_idle", {busy, o_wb_stb}, 0);
        exp_q.delete();

        // randomized sweeps
        rand_ready = 1; rand_stall = 1;
        for (int it = 0; it < 15; it++) begin
            for (int i = 0; i <= MAXA; i++) mem[i] = DW'($urandom_range(0, 12'h7FF));
            sticky_ack = 1'($urandom_range(0, 1));
            start_sweep(int'($urandom_range(0, MAXA)), int'($urandom_range(0, 10)), 0);
            wait_done(0, "rand");
        end
        rand_ready = 0; rand_stall = 0; sticky_ack = 0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
